// File: rtl/pd_mem_arb_pkg.sv
// pd_mem_arb_pkg: shared types for the pd memory arbiter.
//   arb_state_e : arbiter FSM states
//   arb_owner_e : which requester owns the outstanding access
//   LAT_W       : latency counter width (MEM_LATENCY range 1..7)
package pd_mem_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} arb_owner_e;
  localparam int LAT_W = 3;
endpackage

// File: rtl/pd_mem_lat_cnt.sv
// pd_mem_lat_cnt: loadable down-counter tracking the fixed memory latency.
//   clk, reset        : clock, async active-high reset (count -> 0)
//   load_i, load_val_i: load a new count (takes priority over decrement)
//   value_o           : current count, decrements toward 0
//   last_o            : count == 1 (response cycle)
module pd_mem_lat_cnt
  import pd_mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [LAT_W-1:0] load_val_i,
  output logic [LAT_W-1:0] value_o,
  output logic             last_o
);
  logic [LAT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? load_val_i : (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign value_o = cnt_q;
  assign last_o  = cnt_q == LAT_W'(1);
endmodule

// File: rtl/pd_mem_arbiter.sv
// pd_mem_arbiter: shares one fixed-latency memory between fetch (I) and load/store (D).
//   clk, reset           : clock, async active-high reset
//   i_req_* / i_resp_*   : fetch request (read only) and response
//   d_req_* / d_resp_*   : load/store request and response (stores get an ack)
//   mem_*                : issued access; mem_rdata valid MEM_LATENCY cycles after issue
//   PD_MEM_ARB_RR_EN     : when defined, round-robin between I and D; otherwise D has fixed priority
module pd_mem_arbiter
  import pd_mem_arb_pkg::*;
#(
  parameter int AWIDTH      = 32,
  parameter int DWIDTH      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req_valid,
  output logic                i_req_ready,
  input  logic [AWIDTH-1:0]   i_req_addr,
  output logic                i_resp_valid,
  output logic [DWIDTH-1:0]   i_resp_data,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic [AWIDTH-1:0]   d_req_addr,
  input  logic                d_req_we,
  input  logic [DWIDTH-1:0]   d_req_wdata,
  input  logic [DWIDTH/8-1:0] d_req_wstrb,
  output logic                d_resp_valid,
  output logic [DWIDTH-1:0]   d_resp_data,
  output logic                mem_req_valid,
  output logic [AWIDTH-1:0]   mem_addr,
  output logic                mem_we,
  output logic [DWIDTH-1:0]   mem_wdata,
  output logic [DWIDTH/8-1:0] mem_wstrb,
  input  logic [DWIDTH-1:0]   mem_rdata
);
  arb_state_e       state_q, state_d;
  arb_owner_e       owner_q, owner_d;
  logic [LAT_W-1:0] lat_val;
  logic             lat_last, free, resp, i_gnt, d_gnt, gnt;
  pd_mem_lat_cnt u_lat (
    .clk       (clk),
    .reset     (reset),
    .load_i    (gnt),
    .load_val_i(LAT_W'(MEM_LATENCY)),
    .value_o   (lat_val),
    .last_o    (lat_last)
  );
  // The counter is zero exactly when idle; gating on reset keeps every output low while it is held.
  assign free = !reset && (lat_val == '0 || lat_last);
  assign resp = state_q == ARB_BUSY && lat_last;
`ifdef PD_MEM_ARB_RR_EN
  arb_owner_e rr_q;
  assign d_gnt = free && d_req_valid && (!i_req_valid || rr_q == OWN_D);
  assign i_gnt = free && i_req_valid && !d_gnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) rr_q <= OWN_I;
    else rr_q <= i_gnt ? OWN_D : d_gnt ? OWN_I : rr_q;
`else
  assign d_gnt = free && d_req_valid;
  assign i_gnt = free && i_req_valid && !d_req_valid;
`endif
  assign gnt = i_gnt | d_gnt;
  always_comb begin
    state_d = gnt ? ARB_BUSY : resp ? ARB_IDLE : state_q;
    owner_d = i_gnt ? OWN_I : d_gnt ? OWN_D : resp ? OWN_NONE : owner_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_NONE;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  assign i_req_ready   = i_gnt;
  assign d_req_ready   = d_gnt;
  assign i_resp_valid  = resp && owner_q == OWN_I;
  assign d_resp_valid  = resp && owner_q == OWN_D;
  assign i_resp_data   = i_resp_valid ? mem_rdata : '0;
  assign d_resp_data   = d_resp_valid ? mem_rdata : '0;
  assign mem_req_valid = gnt;
  assign mem_addr      = d_gnt ? d_req_addr : i_gnt ? i_req_addr : '0;
  assign mem_we        = d_gnt && d_req_we;
  assign mem_wdata     = d_gnt ? d_req_wdata : '0;
  assign mem_wstrb     = d_gnt ? d_req_wstrb : '0;
endmodule
